// File: rtl/pb_event_gen_pkg.sv
// Shared pong button definitions: FSM state encoding and default repeat timing
// for the game clock.
package pb_event_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam int DEF_REPEAT_DELAY = 8;
    localparam int DEF_REPEAT_RATE  = 4;

endpackage

// File: rtl/pb_event_gen.sv
// Turns a debounced active-low button level into registered single-cycle
// press / release / auto-repeat pulses plus a held level.
module pb_event_gen
    import pb_event_gen_pkg::*;
#(
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int CNT_W        = 16
) (
    input  logic in_clk,
    input  logic rst_n,
    input  logic pb_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_TC  = CNT_W'(REPEAT_RATE - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             pb_d;
    logic             fall, rise;
    logic             press_nx, release_nx, repeat_nx, held_nx;

    assign fall = pb_d & ~pb_in;
    assign rise = ~pb_d & pb_in;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        repeat_nx  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (fall) begin
                    press_nx = 1'b1;
                    state_nx = DELAY;
                end
            end
            DELAY: begin
                // A release wins over a coincident terminal count.
                if (rise) begin
                    release_nx = 1'b1;
                    cnt_nx     = '0;
                    state_nx   = IDLE;
                end else if (cnt == DELAY_TC) begin
                    repeat_nx = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = REPEAT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (rise) begin
                    release_nx = 1'b1;
                    cnt_nx     = '0;
                    state_nx   = IDLE;
                end else if (cnt == RATE_TC) begin
                    repeat_nx = 1'b1;
                    cnt_nx    = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        held_nx = (state_nx != IDLE);
    end

    // pb_d resets high so a button already down at reset release reads as a press.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            pb_d          <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            pb_d          <= pb_in;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
            repeat_pulse  <= repeat_nx;
            held          <= held_nx;
        end
    end

endmodule

// File: tb/tb_pb_event_gen.sv
// Randomized scoreboard bench for pb_event_gen: a time-based model predicts
// each cycle's {press, release, repeat, held} and a monitor compares.
module tb_pb_event_gen;

    localparam int D = 8;
    localparam int R = 4;

    logic in_clk = 1'b0;
    logic rst_n;
    logic pb_in;
    logic press_pulse, release_pulse, repeat_pulse, held;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];

    pb_event_gen #(.REPEAT_DELAY(D), .REPEAT_RATE(R), .CNT_W(16)) dut (
        .in_clk       (in_clk),
        .rst_n        (rst_n),
        .pb_in        (pb_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #10 in_clk = ~in_clk;

    // Model: a button is "down" from its press edge; repeats fire D cycles after
    // the press and every R cycles thereafter; release cancels everything.
    int  cyc = 0;
    int  t_press = 0;
    bit  m_down = 0;
    bit  m_prev = 1;

    always @(posedge in_clk) begin
        bit p, rl, rp;
        int n;
        cyc++;
        p = 0; rl = 0; rp = 0;
        if (!rst_n) begin
            m_down = 0;
            m_prev = 1;
        end else begin
            if (!m_down && m_prev && !pb_in) begin
                p = 1;
                m_down = 1;
                t_press = cyc;
            end else if (m_down && !m_prev && pb_in) begin
                rl = 1;
                m_down = 0;
            end else if (m_down) begin
                n = cyc - t_press;
                if (n == D || (n > D && (n - D) % R == 0)) rp = 1;
            end
            m_prev = pb_in;
        end
        exp_q.push_back({p, rl, rp, m_down});
    end

    always @(negedge in_clk) begin
        logic [3:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {press_pulse, release_pulse, repeat_pulse, held};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d {press,release,repeat,held} got=%b exp=%b",
                         cyc, a, e);
            end
        end
    end

    task automatic step(input logic v);
        @(negedge in_clk);
        #2 pb_in = v;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic do_reset(input int n);
        @(negedge in_clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({press_pulse, release_pulse, repeat_pulse, held} !== 4'b0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=0000",
                     {press_pulse, release_pulse, repeat_pulse, held});
        end
        repeat (n) @(negedge in_clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        pb_in = 1'b0;
        // Button already down through reset: press right after release of reset.
        repeat (3) @(negedge in_clk);
        #2 rst_n = 1'b1;
        hold(0, 5);
        hold(1, 4);
        // Short press of three low samples.
        hold(0, 3);
        hold(1, 4);
        // Long hold through several repeats.
        hold(0, 20);
        hold(1, 3);
        // Release coinciding with the DELAY terminal count.
        hold(0, 8);
        hold(1, 3);
        // Reset mid-hold, button still down afterwards.
        hold(0, 5);
        do_reset(2);
        hold(0, 4);
        hold(1, 3);
        // One-cycle glitch.
        hold(0, 1);
        hold(1, 4);
        // Release coinciding with a REPEAT terminal count.
        hold(0, 12);
        hold(1, 3);
        // Random level runs with occasional resets.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
            hold(logic'($urandom_range(0, 1)), $urandom_range(1, 25));
        end
        hold(1, 3);
        @(negedge in_clk);
        @(negedge in_clk);
        checks++;
        if (checks < 100) begin
            errors++;
            $display("FAIL scoreboard_activity got=%0d exp>=100", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/pb_event_gen.md
Name: pb_event_gen

Overview:
- Consumes the clean, active-low level from debounce_pb and converts it into single-cycle button events for the pong paddle/menu logic.
- Events are press, release and auto-repeat while held.
- Sits between debounce_pb and the paddle controller; one instance per button.

Parameters:
REPEAT_DELAY, 8, cycles from press detection to first repeat pulse (>=2)
REPEAT_RATE, 4, cycles between subsequent repeat pulses (>=2)
CNT_W, 16, counter width; must hold max(REPEAT_DELAY, REPEAT_RATE)-1

Ports:
in_clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
pb_in  input  1  debounced button level, active-low (1 = released), synchronous to in_clk
press_pulse  output  1  one-cycle pulse on press
release_pulse  output  1  one-cycle pulse on release
repeat_pulse  output  1  one-cycle pulse per auto-repeat interval while held
held  output  1  high while button considered pressed

Behaviour:
- Single clock in_clk; reset is asynchronous, active-low (rst_n). All outputs registered.
- Reset (rst_n=0): all outputs 0 immediately (async); pb_d (previous sample) = 1; counter = 0; state = IDLE.
- Edge detection on sampled pb_in versus pb_d:
  - fall = pb_d & ~pb_in
  - rise = ~pb_d & pb_in
  - pb_d <= pb_in every edge.
- Latency: the event output is high for exactly the one cycle following the edge at which the transition is sampled.
- Button low at reset release counts as a press (pb_d resets to 1).
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE: on fall -> press_pulse, cnt=0, go DELAY.
  - DELAY: on rise -> release_pulse, go IDLE. Else if cnt==REPEAT_DELAY-1 -> repeat_pulse, cnt=0, go REPEAT. Else cnt++.
  - REPEAT: on rise -> release_pulse, go IDLE. Else if cnt==REPEAT_RATE-1 -> repeat_pulse, cnt=0. Else cnt++.
- held = 1 in DELAY or REPEAT, registered together with the state.
- Priority: rise beats terminal count in the same cycle. Only release_pulse fires; repeat is suppressed.
- At most one of press/release/repeat is high in any cycle.
- Counter never wraps: it clears on terminal count, on entry to DELAY and on return to IDLE.
- A fall while in DELAY/REPEAT is impossible (already low); if pb_d somehow mismatches, the FSM is re-synchronised by the next edge. No illegal-state lockup: default branch -> IDLE.
- Reset mid-hold: outputs drop in the same instant. No release_pulse is generated. After reset, if pb_in is still 0, a fresh press_pulse occurs one cycle after rst_n rises.
- One-cycle low glitch: press_pulse and release_pulse on consecutive cycles, no repeat.

Decomposition:
- Shared pong package holds:
  - state encoding localparams (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2)
  - default REPEAT_DELAY/REPEAT_RATE for the game clock.
- No sub-module needed. An optional top-level pairing (pb_button_if = debounce_pb + pb_event_gen) lives outside this block.

Test Plan (REPEAT_DELAY=8, REPEAT_RATE=4, in_clk period 20ns):
1. Hold pb_in=0 during reset, release rst_n at edge R -> all outputs 0 during reset; press_pulse=1 in cycle R+1 only; held=1 from R+1.
2. pb_in low sampled at edge P, high sampled at edge P+3 -> press_pulse cycle P+1; release_pulse cycle P+4; held cycles P+1..P+3; repeat_pulse never.
3. pb_in low from edge P for 20 cycles -> repeat_pulse in cycles P+9, P+13, P+17; held stays 1; after release, one release_pulse.
4. Release sampled on the same edge as a DELAY terminal count (rise at edge P+8) -> release_pulse cycle P+9; repeat_pulse stays 0; state IDLE.
5. rst_n asserted at edge P+5 mid-hold -> held, all pulses 0 immediately; no release_pulse; press_pulse one cycle after rst_n deasserts if pb_in still 0.
6. One-cycle low glitch at edge G -> press_pulse cycle G+1; release_pulse cycle G+2; no repeat; held high for one cycle.
